// File: rtl/axi_mem_pkg.sv
// Shared definitions for the AXI burst-to-beat address generator.
//   burst_t   : AXI burst encodings
//   state_t   : address generator FSM states
//   next_addr : next beat address within a 4KB page (low 12 bits only)
//   burst_err : illegal SIZE/BURST/WRAP-length decode for a command
package axi_mem_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam int PAGE_BITS = 12;

    // Only the page offset ever changes: INCR never carries past bit 11 and
    // the largest legal wrap window (16 beats x 128 bytes) lies inside a page.
    // For legal WRAP bursts addr+nb never exceeds lower+wrap_bytes, so a
    // 12-bit compare is exact even when lower+wrap_bytes is the page end.
    function automatic logic [PAGE_BITS-1:0] next_addr(
        input logic [PAGE_BITS-1:0] addr,
        input logic [2:0]           size,
        input burst_t               burst,
        input logic [7:0]           len
    );
        logic [PAGE_BITS-1:0] nb;
        logic [PAGE_BITS-1:0] wrap_bytes;
        logic [PAGE_BITS-1:0] lower;
        logic [PAGE_BITS-1:0] inc;
        nb         = 12'd1 << size;
        wrap_bytes = nb * ({4'd0, len} + 12'd1);
        lower      = addr & ~(wrap_bytes - 12'd1);
        inc        = addr + nb;
        case (burst)
            BURST_INCR: next_addr = (addr & ~(nb - 12'd1)) + nb;
            BURST_WRAP: next_addr = (inc == lower + wrap_bytes) ? lower : inc;
            default:    next_addr = addr;
        endcase
    endfunction

    function automatic logic burst_err(
        input logic [PAGE_BITS-1:0] addr,
        input logic [7:0]           len,
        input logic [2:0]           size,
        input burst_t               burst,
        input logic [2:0]           max_size
    );
        logic len_ok;
        logic aligned;
        len_ok  = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        aligned = (addr & ((12'd1 << size) - 12'd1)) == 12'd0;
        burst_err = (size > max_size) || (burst == BURST_RSVD) ||
                    ((burst == BURST_WRAP) && (!len_ok || !aligned));
    endfunction

endpackage

// File: rtl/axi_mem_burst_addr_gen_if.sv
// Bus bundle for the burst address generator.
//   Command side : AxADDR, AxLEN, AxSIZE, AxBURST, AxID, AxVALID -> AxREADY
//   Beat side    : AddrOut, AddrId, AddrLast, AddrErr, AddrValid <- AddrReady
//   slave  : view of the address generator
//   master : view of the driving/consuming environment
interface axi_mem_burst_addr_gen_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ADDR_WIDTH-1:0] AxADDR;
    logic [7:0]            AxLEN;
    logic [2:0]            AxSIZE;
    logic [1:0]            AxBURST;
    logic [ID_WIDTH-1:0]   AxID;
    logic                  AxVALID;
    logic                  AxREADY;

    logic [ADDR_WIDTH-1:0] AddrOut;
    logic [ID_WIDTH-1:0]   AddrId;
    logic                  AddrLast;
    logic                  AddrErr;
    logic                  AddrValid;
    logic                  AddrReady;

    modport slave (
        input  AxADDR, AxLEN, AxSIZE, AxBURST, AxID, AxVALID, AddrReady,
        output AxREADY, AddrOut, AddrId, AddrLast, AddrErr, AddrValid
    );

    modport master (
        output AxADDR, AxLEN, AxSIZE, AxBURST, AxID, AxVALID, AddrReady,
        input  AxREADY, AddrOut, AddrId, AddrLast, AddrErr, AddrValid
    );
endinterface

// File: rtl/axi_mem_cmd_fifo.sv
// Registered command queue with simultaneous push/pop; a pop frees a slot
// for a push in the same cycle even when full. DEPTH=1 is a single register.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_push, i_data : write request and entry
//   i_pop          : read request (head is dropped at the clock edge)
//   o_data         : head entry
//   o_full/o_empty : occupancy flags
module axi_mem_cmd_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    generate
        if (DEPTH == 1) begin : g_single
            T r_data;
            always_ff @(posedge i_clk) begin
                if (w_push) begin
                    r_data <= i_data;
                end
            end
            assign o_data = r_data;
        end else begin : g_ring
            localparam int PW = $clog2(DEPTH);
            T              r_mem [DEPTH];
            logic [PW-1:0] r_wr_ptr;
            logic [PW-1:0] r_rd_ptr;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + PW'(1);
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + PW'(1);
                    end
                end
            end

            always_ff @(posedge i_clk) begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= i_data;
                end
            end

            assign o_data = r_mem[r_rd_ptr];
        end
    endgenerate
endmodule

// File: rtl/axi_mem_burst_addr_gen.sv
// AXI burst-to-beat address generator: queues AR/AW commands and expands
// each into one address per beat (FIXED/INCR/WRAP, narrow, unaligned).
//   ACLK, ARESETn : clock, async active-low reset
//   bus (slave)   : command channel in (AxVALID/AxREADY), beat channel out
//                   (AddrValid/AddrReady) with AddrOut/AddrId/AddrLast/AddrErr
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no beat presented; pops the queue as soon as it is non-empty
// ST_BURST| AddrValid high, presenting beats of the current burst
module axi_mem_burst_addr_gen
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_BYTES = 8,
    parameter int CMD_DEPTH  = 2
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    axi_mem_burst_addr_gen_if.slave  bus
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_BYTES));

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        burst_t                burst;
        logic [ID_WIDTH-1:0]   id;
    } cmd_t;

    cmd_t                  w_push_cmd;
    cmd_t                  w_pop_cmd;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_beat_acc;
    logic [ADDR_WIDTH-1:0] w_next_addr;

    state_t                r_state;
    logic                  r_rdy_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ID_WIDTH-1:0]   r_id;
    logic [7:0]            r_cnt;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    burst_t                r_burst;
    logic                  r_last;
    logic                  r_err;
    logic                  r_valid;

    always_comb begin
        w_push_cmd.addr  = bus.AxADDR;
        w_push_cmd.len   = bus.AxLEN;
        w_push_cmd.size  = bus.AxSIZE;
        w_push_cmd.burst = burst_t'(bus.AxBURST);
        w_push_cmd.id    = bus.AxID;
    end

    assign w_beat_acc = r_valid & bus.AddrReady;
    // Pop when idle, or on the last beat's accept so the next burst follows
    // without a bubble.
    assign w_pop  = ~w_empty & ((r_state == ST_IDLE) | (w_beat_acc & r_last));
    // r_rdy_en holds AxREADY low while reset is asserted.
    assign bus.AxREADY = r_rdy_en & (~w_full | w_pop);
    assign w_push = bus.AxVALID & bus.AxREADY;

    axi_mem_cmd_fifo #(
        .T     (cmd_t),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .i_clk   (ACLK),
        .i_rst_n (ARESETn),
        .i_push  (w_push),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_data  (w_pop_cmd),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_next_addr = r_addr;
        w_next_addr[PAGE_BITS-1:0] = next_addr(r_addr[PAGE_BITS-1:0], r_size, r_burst, r_len);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state  <= ST_IDLE;
            r_rdy_en <= 1'b0;
            r_addr   <= '0;
            r_id     <= '0;
            r_cnt    <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= BURST_FIXED;
            r_last   <= 1'b0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_pop) begin
                r_state <= ST_BURST;
                r_valid <= 1'b1;
                r_addr  <= w_pop_cmd.addr;
                r_id    <= w_pop_cmd.id;
                r_cnt   <= w_pop_cmd.len;
                r_len   <= w_pop_cmd.len;
                r_size  <= w_pop_cmd.size;
                r_burst <= w_pop_cmd.burst;
                r_last  <= (w_pop_cmd.len == 8'd0);
                r_err   <= burst_err(w_pop_cmd.addr[PAGE_BITS-1:0], w_pop_cmd.len,
                                     w_pop_cmd.size, w_pop_cmd.burst, MAX_SIZE);
            end else if (w_beat_acc) begin
                if (r_last) begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_err   <= 1'b0;
                end else begin
                    r_cnt  <= r_cnt - 8'd1;
                    r_last <= (r_cnt == 8'd1);
                    // Errored bursts keep the start address on every beat.
                    if (!r_err) begin
                        r_addr <= w_next_addr;
                    end
                end
            end
        end
    end

    assign bus.AddrOut   = r_addr;
    assign bus.AddrId    = r_id;
    assign bus.AddrLast  = r_last;
    assign bus.AddrErr   = r_err;
    assign bus.AddrValid = r_valid;
endmodule

// File: tb/tb_axi_mem_burst_addr_gen.sv
module tb_axi_mem_burst_addr_gen;
    localparam int AW    = 32;
    localparam int IW    = 4;
    localparam int DB    = 8;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_mem_burst_addr_gen_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    axi_mem_burst_addr_gen #(
        .ADDR_WIDTH (AW),
        .ID_WIDTH   (IW),
        .DATA_BYTES (DB),
        .CMD_DEPTH  (DEPTH)
    ) dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic        last;
        logic        err;
    } beat_t;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    rdy_mode = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: whole burst expanded from the address rules with plain arithmetic.
    task automatic model_cmd(input logic [31:0] a, input int len, input int size,
                             input int burst, input logic [3:0] id);
        logic [31:0] nb, wb, lower, ba, iu;
        bit          err;
        beat_t       b;
        nb    = 32'd1 << size;
        wb    = nb * 32'(len + 1);
        err   = (size > 3) || (burst == 3) ||
                (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
                (burst == 2 && (a % nb) != 32'd0);
        lower = a & ~(wb - 32'd1);
        for (int i = 0; i <= len; i++) begin
            iu = 32'(i);
            if (err || burst == 0 || i == 0)
                ba = a;
            else if (burst == 1)
                ba = (a & 32'hFFFF_F000) | (((a & ~(nb - 32'd1)) + iu * nb) & 32'h0000_0FFF);
            else
                ba = lower + ((a - lower + iu * nb) % wb);
            b.addr = ba;
            b.id   = id;
            b.last = (i == len);
            b.err  = err;
            exp_q.push_back(b);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_cmd(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id);
        int waitc;
        waitc = 0;
        bus.AxADDR  = a;
        bus.AxLEN   = len;
        bus.AxSIZE  = size;
        bus.AxBURST = burst;
        bus.AxID    = id;
        bus.AxVALID = 1'b1;
        @(negedge clk);
        while (bus.AxREADY !== 1'b1 && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        if (bus.AxREADY === 1'b1)
            model_cmd(a, int'(len), int'(size), int'(burst), id);
        else
            check("ax_timeout", 32'(bus.AxREADY), 32'd1);
        @(posedge clk);
        #1;
        bus.AxVALID = 1'b0;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.AddrReady = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.AddrReady = 1'b0;
                1:       bus.AddrReady = 1'b1;
                default: bus.AddrReady = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Beat monitor: scoreboard compare on every accepted beat, hold check under stall.
    logic        prev_stall = 1'b0;
    logic [31:0] p_addr;
    logic [3:0]  p_id;
    logic        p_last, p_err;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(bus.AddrValid), 32'd1);
                check("stall_addr",  bus.AddrOut, p_addr);
                check("stall_id",    32'(bus.AddrId), 32'(p_id));
                check("stall_last",  32'(bus.AddrLast), 32'(p_last));
                check("stall_err",   32'(bus.AddrErr), 32'(p_err));
            end
            if (bus.AddrValid && bus.AddrReady) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(bus.AddrValid), 32'd0);
                end else begin
                    check("beat_addr", bus.AddrOut, exp_q[0].addr);
                    check("beat_id",   32'(bus.AddrId), 32'(exp_q[0].id));
                    check("beat_last", 32'(bus.AddrLast), 32'(exp_q[0].last));
                    check("beat_err",  32'(bus.AddrErr), 32'(exp_q[0].err));
                    exp_q.delete(0);
                end
            end
            prev_stall <= bus.AddrValid && !bus.AddrReady;
            p_addr     <= bus.AddrOut;
            p_id       <= bus.AddrId;
            p_last     <= bus.AddrLast;
            p_err      <= bus.AddrErr;
        end
    end

    initial begin
        logic [31:0] a;
        logic [7:0]  l;
        logic [2:0]  s;
        logic [1:0]  bt;

        bus.AxVALID = 1'b0;
        bus.AxADDR  = '0;
        bus.AxLEN   = '0;
        bus.AxSIZE  = '0;
        bus.AxBURST = '0;
        bus.AxID    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_axready", 32'(bus.AxREADY), 32'd0);
        check("rst_valid",   32'(bus.AddrValid), 32'd0);
        check("rst_addr",    bus.AddrOut, 32'd0);
        check("rst_id",      32'(bus.AddrId), 32'd0);
        check("rst_last",    32'(bus.AddrLast), 32'd0);
        check("rst_err",     32'(bus.AddrErr), 32'd0);
        cycle();
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("axready_after_rst", 32'(bus.AxREADY), 32'd1);
        cycle();

        rdy_mode = 1;
        cycle();
        // INCR unaligned start, WRAP, INCR page wrap
        send_cmd(32'h0000_1004, 8'd3, 3'd2, 2'b01, 4'h1);
        wait_drain();
        send_cmd(32'h0000_2038, 8'd3, 3'd3, 2'b10, 4'h2);
        wait_drain();
        send_cmd(32'h0000_3FFC, 8'd1, 3'd2, 2'b01, 4'h3);
        wait_drain();

        // Back-to-back bursts with no bubble
        send_cmd(32'h0000_4000, 8'd1, 3'd3, 2'b01, 4'h4);
        send_cmd(32'h0000_5000, 8'd1, 3'd3, 2'b01, 4'h5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_bubble", 32'(bus.AddrValid), 32'd1);
        end
        wait_drain();

        // Queue full: AxREADY low until the in-flight burst finishes
        rdy_mode = 0;
        cycle();
        cycle();
        send_cmd(32'h0000_6000, 8'd1, 3'd2, 2'b01, 4'h6);
        send_cmd(32'h0000_6100, 8'd1, 3'd2, 2'b01, 4'h7);
        send_cmd(32'h0000_6200, 8'd1, 3'd2, 2'b01, 4'h8);
        bus.AxVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_axready", 32'(bus.AxREADY), 32'd0);
        end
        cycle();
        rdy_mode = 1;
        send_cmd(32'h0000_6300, 8'd1, 3'd2, 2'b01, 4'h9);
        wait_drain();

        // Oversized beat: errored, address held
        send_cmd(32'h0000_7008, 8'd2, 3'd4, 2'b01, 4'hA);
        wait_drain();

        // Stalls then reset mid-burst with a queued command
        rdy_mode = 2;
        send_cmd(32'h0000_8000, 8'd15, 3'd2, 2'b01, 4'hB);
        send_cmd(32'h0000_8800, 8'd3, 3'd2, 2'b01, 4'hC);
        repeat (3) cycle();
        @(negedge clk);
        check("midburst_valid", 32'(bus.AddrValid), 32'd1);
        cycle();
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mrst_axready", 32'(bus.AxREADY), 32'd0);
        check("mrst_valid",   32'(bus.AddrValid), 32'd0);
        check("mrst_addr",    bus.AddrOut, 32'd0);
        check("mrst_id",      32'(bus.AddrId), 32'd0);
        check("mrst_last",    32'(bus.AddrLast), 32'd0);
        check("mrst_err",     32'(bus.AddrErr), 32'd0);
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(bus.AddrValid), 32'd0);
        end
        cycle();
        send_cmd(32'h0000_9ABC, 8'd2, 3'd0, 2'b01, 4'hD);
        wait_drain();

        // Randomized commands with random back-pressure
        for (int k = 0; k < 30; k++) begin
            bt = 2'($urandom_range(0, 3));
            s  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            a  = $urandom();
            if (bt == 2'b10) begin
                case ($urandom_range(0, 3))
                    0:       l = 8'd1;
                    1:       l = 8'd3;
                    2:       l = 8'd7;
                    default: l = 8'd15;
                endcase
                if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << s) - 32'd1);
                if ($urandom_range(0, 5) == 0) l = 8'd2;
            end else begin
                l = 8'($urandom_range(0, 15));
            end
            send_cmd(a, l, s, bt, 4'($urandom_range(0, 15)));
        end
        rdy_mode = 1;
        wait_drain();
        repeat (2) @(negedge clk);
        check("end_idle", 32'(bus.AddrValid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
